potential_decay_array: RTL and testbench
========================================

Name: potential_decay_array

Overview:
- Clocked, parametrised successor of the single-neuron FP32 potential decay stage.
- Holds the membrane potential (IEEE-754 single) and decay rate for NEURONS neurons.
- Accepts potential updates from the potential adder side. On each timestep `start` it sweeps every neuron, decays it by exponent shift, writes it back and streams it out under valid/ready handshake.
- Sits between the potential adder array and the spike/threshold comparator.

Parameters:
- NEURONS, 32, number of neurons held; legal range 2..4096.
- ADDR_W, $clog2(NEURONS), neuron address width.
- TS_W, 16, timestep counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  initialisation write strobe
- cfg_addr  in  ADDR_W  neuron to initialise
- cfg_potential  in  32  initial FP32 potential
- cfg_rate  in  4  decay rate code
- upd_valid  in  1  new potential from adder
- upd_ready  out  1  high only in IDLE
- upd_addr  in  ADDR_W  neuron being updated
- upd_potential  in  32  new FP32 potential
- start  in  1  timestep pulse; begins sweep
- out_valid  out  1  decayed value available
- out_ready  in  1  consumer accepts
- out_addr  out  ADDR_W  neuron of out_potential
- out_potential  out  32  decayed FP32 potential
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end
- ts_count  out  TS_W  completed sweeps, wraps

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - All potentials become 0x00000000; all rates become 4'b0001.
  - State goes to IDLE; index goes to 0.
  - out_valid, out_addr, out_potential, busy, done and ts_count go to 0; upd_ready goes to 1 (IDLE).
  - Reset mid-sweep aborts immediately; no done pulse.
- States: IDLE, SWEEP, MIX (feature only), FINISH.
- IDLE:
  - cfg_we writes potential and rate at cfg_addr.
  - upd_valid writes potential at upd_addr.
  - Same address in the same cycle: cfg wins.
  - start moves the FSM to SWEEP with idx=0. If an update is written in the same cycle, the sweep sees the updated value.
  - cfg/upd in SWEEP/MIX/FINISH are ignored; upd_ready=0.
- SWEEP:
  - Advances when the output register is empty or out_ready=1.
  - On advance: decay mem[idx], write the result back to mem[idx], load out_potential/out_addr=idx, set out_valid=1, idx++.
  - Otherwise hold; no write-back.
  - First out_valid appears 2 clk edges after the start edge.
  - Throughput is 1 neuron/cycle with out_ready held high.
- FINISH:
  - Entered after idx=NEURONS-1 is loaded.
  - Waits for the final handshake.
  - Next cycle: done=1 for one cycle, ts_count++ (wraps modulo 2^TS_W), busy=0, return to IDLE.
  - busy=1 in SWEEP, MIX and FINISH.
- out_valid drops after a handshake unless a new value is loaded in the same cycle. out_potential is stable while out_valid=1 and out_ready=0.
- Decay arithmetic (sign s, exponent e, mantissa m):
  - Rate 0001 divides by 1 (shift k=0); 0010 divides by 2 (k=1); 0100 divides by 4 (k=2); 1000 divides by 8 (k=3). Any other code divides by 1.
  - e=255 (Inf/NaN): pass unchanged.
  - e=0 (zero/denormal): flush to {s,31'b0}.
  - e<=k: underflow, flush to {s,31'b0}. There is no exponent wrap-around.
  - Else: {s, e-k, m}.
- NEURONS not a power of two: idx stops at NEURONS-1. cfg/upd addresses >= NEURONS are ignored.

Optional Feature:
- Macro DECAY_MIX_EN.
- Defined:
  - Rate 4'b0011 yields x/2 + x/4 (×0.75) via one instance of the shared Addition_Subtraction unit. Operands are {s,e-1,m} and {s,e-2,m}, each flushed per the rules above.
  - The sweep spends one extra cycle in MIX for that neuron; the adder output is registered before write-back/out.
  - e=255 passes unchanged.
- Undefined: 4'b0011 divides by 1; the MIX state and adder are not instantiated.

Test Plan:
- Reset, cfg neuron 0 = 0x41DED852 with rate 0010, start, out_ready=1 -> first out_valid 2 cycles after start, out_addr=0, out_potential=0x415ED852. Rates 0100/1000 give 0x40DED852/0x405ED852 and rate 0001 gives 0x41DED852. done pulses once; ts_count=1.
- Neuron 3 = 0x01000000 rate 1000 -> 0x00000000; neuron 4 = 0x81000000 rate 1000 -> 0x80000000; 0x7F800000 rate 1000 -> 0x7F800000 unchanged.
- Two consecutive sweeps on 0x41DED852 rate 0010 -> 0x415ED852 then 0x40DED852 (write-back verified); ts_count=2.
- Hold out_ready=0 for 5 cycles mid-sweep -> out_potential/out_addr stable; no neuron is skipped or duplicated; NEURONS outputs total in ascending addr.
- upd_valid addr 2 = 0x40000000 in the same cycle as start, rate 0010 -> out for addr 2 = 0x3F800000. upd_valid during SWEEP -> upd_ready=0, memory unchanged. rst asserted mid-sweep -> all outputs 0 next cycle, no done.
- With DECAY_MIX_EN: 0x41DED852 rate 0011 -> Addition_Subtraction(0x415ED852, 0x40DED852) result (0x41A7223E); that neuron's out_valid is one cycle later than in the non-mix timing. Without the macro -> 0x41DED852.

Source files
------------

// File: rtl/potential_decay_array.sv
// Per-neuron FP32 membrane potential store; each start sweeps all neurons, decays by exponent shift, writes back and streams out.
// Latency: first out_valid two edges after start is driven (state edge, then load edge), then 1 neuron/cycle. Backpressure: sweep stalls while the output register is full and out_ready=0.
// Optional DECAY_MIX_EN: rate 4'b0011 decays by x/2 + x/4 through an extra MIX cycle.
module potential_decay_array #(
    parameter int NEURONS = 32,
    parameter int ADDR_W  = $clog2(NEURONS),
    parameter int TS_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [31:0]       cfg_potential,
    input  logic [3:0]        cfg_rate,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [31:0]       upd_potential,
    input  logic              start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_potential,
    output logic              busy,
    output logic              done,
    output logic [TS_W-1:0]   ts_count
);

    typedef enum logic [1:0] {IDLE, SWEEP, MIX, FINISH} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NEURONS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       pot_mem  [NEURONS];
    logic [3:0]        rate_mem [NEURONS];
    logic              adv;
    logic [31:0]       cur_pot;
    logic [3:0]        cur_rate;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < NEURONS;
    endfunction

    // Shift the exponent down by k; anything that would reach e<=0 flushes to signed zero.
    function automatic logic [31:0] decay(input logic [31:0] x, input logic [3:0] rate);
        logic [7:0] k;
        case (rate)
            4'b0010: k = 8'd1;
            4'b0100: k = 8'd2;
            4'b1000: k = 8'd3;
            default: k = 8'd0;
        endcase
        if (x[30:23] == 8'hFF)
            return x;
        else if (x[30:23] <= k)
            return {x[31], 31'b0};
        else
            return {x[31], x[30:23] - k, x[22:0]};
    endfunction

`ifdef DECAY_MIX_EN
    logic [31:0] mix_reg;

    // Same-sign add of {s,e-1,m} and {s,e-2,m}: the sum is 3*M scaled, rounded to nearest even.
    function automatic logic [31:0] mix75(input logic [31:0] x);
        logic [7:0]  e;
        logic [25:0] s;
        logic [24:0] mr;
        logic [8:0]  er;
        logic        rnd;
        logic        stk;
        e = x[30:23];
        if (e == 8'hFF) return x;
        if (e <= 8'd1) return {x[31], 31'b0};
        if (e == 8'd2) return {x[31], 8'd1, x[22:0]};
        s = {1'b0, 1'b1, x[22:0], 1'b0} + {2'b0, 1'b1, x[22:0]};
        if (s[25]) begin
            mr  = {1'b0, s[25:2]};
            rnd = s[1];
            stk = s[0];
            er  = {1'b0, e};
        end else begin
            mr  = {1'b0, s[24:1]};
            rnd = s[0];
            stk = 1'b0;
            er  = {1'b0, e} - 9'd1;
        end
        if (rnd && (stk || mr[0])) mr = mr + 25'd1;
        if (mr[24]) begin
            mr = mr >> 1;
            er = er + 9'd1;
        end
        if (er >= 9'd255) return {x[31], 8'hFF, 23'b0};
        return {x[31], er[7:0], mr[22:0]};
    endfunction
`endif

    assign adv       = !out_valid || out_ready;
    assign cur_pot   = pot_mem[idx];
    assign cur_rate  = rate_mem[idx];
    assign upd_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            out_valid     <= 1'b0;
            out_addr      <= '0;
            out_potential <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ts_count      <= '0;
            for (int i = 0; i < NEURONS; i++) begin
                pot_mem[i]  <= 32'h0;
                rate_mem[i] <= 4'b0001;
            end
`ifdef DECAY_MIX_EN
            mix_reg       <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (upd_valid && in_range(upd_addr)) pot_mem[upd_addr] <= upd_potential;
                    // Issued after the update so cfg wins on an address collision.
                    if (cfg_we && in_range(cfg_addr)) begin
                        pot_mem[cfg_addr]  <= cfg_potential;
                        rate_mem[cfg_addr] <= cfg_rate;
                    end
                    if (start) begin
                        state <= SWEEP;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (adv) begin
`ifdef DECAY_MIX_EN
                        if (cur_rate == 4'b0011) begin
                            mix_reg <= mix75(cur_pot);
                            state   <= MIX;
                        end else
`endif
                        begin
                            pot_mem[idx]  <= decay(cur_pot, cur_rate);
                            out_potential <= decay(cur_pot, cur_rate);
                            out_addr      <= idx;
                            out_valid     <= 1'b1;
                            if (idx == LAST) state <= FINISH;
                            else             idx   <= idx + 1'b1;
                        end
                    end
                end
`ifdef DECAY_MIX_EN
                MIX: begin
                    if (adv) begin
                        pot_mem[idx]  <= mix_reg;
                        out_potential <= mix_reg;
                        out_addr      <= idx;
                        out_valid     <= 1'b1;
                        if (idx == LAST) state <= FINISH;
                        else begin
                            idx   <= idx + 1'b1;
                            state <= SWEEP;
                        end
                    end
                end
`endif
                FINISH: begin
                    if (adv) begin
                        done     <= 1'b1;
                        ts_count <= ts_count + 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_potential_decay_array.sv
// Directed bench for potential_decay_array with a field-level FP32 decay model and a per-cycle output scoreboard.
module tb_potential_decay_array;
    localparam int N  = 6;
    localparam int AW = 3;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [31:0]   cfg_potential;
    logic [3:0]    cfg_rate;
    logic          upd_valid;
    logic          upd_ready;
    logic [AW-1:0] upd_addr;
    logic [31:0]   upd_potential;
    logic          start;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_potential;
    logic          busy;
    logic          done;
    logic [TW-1:0] ts_count;

    potential_decay_array #(.NEURONS(N), .ADDR_W(AW), .TS_W(TW)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_potential(cfg_potential), .cfg_rate(cfg_rate),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_potential(upd_potential),
        .start(start), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_potential(out_potential), .busy(busy), .done(done), .ts_count(ts_count)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_out  = 0;
    int          done_cnt = 0;
    logic [31:0] m_pot  [N];
    logic [3:0]  m_rate [N];
    logic [31:0] got    [N];
    int          exp_addr[$];
    logic [31:0] exp_pot[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

`ifdef DECAY_MIX_EN
    function automatic real fval(input logic [7:0] e, input logic [22:0] m);
        return (1.0 + real'(m) / 8388608.0) * (2.0 ** (real'(e) - 127.0));
    endfunction

    // x/2 + x/4 as exact reals, then rounded to the nearest FP32 (ties to even).
    function automatic logic [31:0] m_mix(input logic [31:0] x);
        int    e;
        int    ex;
        real   a;
        real   b;
        real   sum;
        real   sc;
        real   fr;
        longint i;
        e = int'(x[30:23]);
        if (e == 255) return x;
        a = (e - 1 <= 0) ? 0.0 : fval(8'(e - 1), x[22:0]);
        b = (e - 2 <= 0) ? 0.0 : fval(8'(e - 2), x[22:0]);
        sum = a + b;
        if (sum == 0.0) return {x[31], 31'b0};
        ex = 0;
        while (sum >= 2.0) begin sum = sum / 2.0; ex++; end
        while (sum < 1.0) begin sum = sum * 2.0; ex--; end
        sc = sum * 8388608.0;
        i  = longint'($floor(sc));
        fr = sc - real'(i);
        if (fr > 0.5 || (fr == 0.5 && i[0])) i++;
        if (i == 64'd16777216) begin i = 64'd8388608; ex++; end
        if (ex + 127 >= 255) return {x[31], 8'hFF, 23'b0};
        return {x[31], 8'(ex + 127), 23'(i)};
    endfunction
`endif

    // Division by 2^k expressed on the exponent field; results below the normal range become signed zero.
    function automatic logic [31:0] m_decay(input logic [31:0] x, input logic [3:0] r);
        int k;
        int e;
`ifdef DECAY_MIX_EN
        if (r == 4'b0011) return m_mix(x);
`endif
        k = (r == 4'b0010) ? 1 : (r == 4'b0100) ? 2 : (r == 4'b1000) ? 3 : 0;
        e = int'(x[30:23]);
        if (e == 255) return x;
        if (e - k <= 0) return {x[31], 31'b0};
        return {x[31], 8'(e - k), x[22:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pot[i]  = 32'h0;
            m_rate[i] = 4'b0001;
        end
        exp_addr.delete();
        exp_pot.delete();
    endtask

    task automatic model_sweep();
        for (int i = 0; i < N; i++) begin
            m_pot[i] = m_decay(m_pot[i], m_rate[i]);
            exp_addr.push_back(i);
            exp_pot.push_back(m_pot[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_cfg(input int a, input logic [31:0] p, input logic [3:0] r);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_potential = p; cfg_rate = r;
        if (a < N) begin m_pot[a] = p; m_rate[a] = r; end
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        model_sweep();
        n_out = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_ts, input int exp_done);
        int cnt;
        cnt = 0;
        while (done !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        if (cnt >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse", cnt);
        end
        chk("busy_at_done", 32'(busy), 32'd0);
        tick();
        chk("done_width", 32'(done), 32'd0);
        chk("ts_count", 32'(ts_count), 32'(exp_ts));
        chk("done_count", 32'(done_cnt), 32'(exp_done));
        chk("outputs_per_sweep", 32'(n_out), 32'(N));
        chk("queue_drained", 32'(exp_addr.size()), 32'd0);
    endtask

    // Scoreboard: sampled mid-cycle, away from the active edge.
    logic          hold_chk = 1'b0;
    logic [AW-1:0] h_addr;
    logic [31:0]   h_pot;
    always @(negedge clk) begin
        if (rst) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_addr", 32'(out_addr), 32'(h_addr));
                chk("stall_pot", out_potential, h_pot);
            end
            hold_chk = out_valid && !out_ready;
            h_addr   = out_addr;
            h_pot    = out_potential;
            if (out_valid && out_ready) begin
                if (exp_addr.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got addr %0d pot %h, expected none", out_addr, out_potential);
                end else begin
                    chk("out_addr", 32'(out_addr), 32'(exp_addr.pop_front()));
                    chk("out_pot", out_potential, exp_pot.pop_front());
                end
                got[out_addr] = out_potential;
                n_out++;
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_potential = '0; cfg_rate = '0;
        upd_valid = 1'b0; upd_addr = '0; upd_potential = '0; start = 1'b0; out_ready = 1'b1;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_pot", out_potential, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ts", 32'(ts_count), 32'd0);
        chk("rst_upd_ready", 32'(upd_ready), 32'd1);

        // Sweep 1: each rate code and the boundary exponents.
        do_cfg(0, 32'h41DED852, 4'b0010);
        do_cfg(1, 32'h41DED852, 4'b0100);
        do_cfg(2, 32'h41DED852, 4'b1000);
        do_cfg(3, 32'h01000000, 4'b1000);
        do_cfg(4, 32'h81000000, 4'b1000);
        do_cfg(5, 32'h7F800000, 4'b1000);
        do_cfg(7, 32'h12345678, 4'b0010);
        do_start();
        chk("lat_edge1_valid", 32'(out_valid), 32'd0);
        chk("lat_busy", 32'(busy), 32'd1);
        tick();
        chk("lat_edge2_valid", 32'(out_valid), 32'd1);
        chk("lat_first_addr", 32'(out_addr), 32'd0);
        chk("lat_first_pot", out_potential, 32'h415ED852);
        wait_done(1, 1);
        chk("lit_rate2", got[0], 32'h415ED852);
        chk("lit_rate4", got[1], 32'h40DED852);
        chk("lit_rate8", got[2], 32'h405ED852);
        chk("lit_underflow", got[3], 32'h00000000);
        chk("lit_neg_underflow", got[4], 32'h80000000);
        chk("lit_inf", got[5], 32'h7F800000);

        // Sweep 2: write-back on neuron 0, rate 0001 and rate 0011.
        do_cfg(1, 32'h41DED852, 4'b0001);
        do_cfg(5, 32'h41DED852, 4'b0011);
        do_start();
        wait_done(2, 2);
        chk("lit_writeback", got[0], 32'h40DED852);
        chk("lit_rate1", got[1], 32'h41DED852);
`ifdef DECAY_MIX_EN
        chk("lit_mix", got[5], 32'h41A7223E);
`else
        chk("lit_rate3_plain", got[5], 32'h41DED852);
`endif

        // Sweep 3: update coinciding with start, update ignored mid-sweep, output stall.
        do_cfg(2, 32'h3F000000, 4'b0010);
        upd_valid = 1'b1; upd_addr = 3'd2; upd_potential = 32'h40000000;
        m_pot[2] = 32'h40000000;
        do_start();
        upd_valid = 1'b0;
        tick();
        tick();
        upd_valid = 1'b1; upd_addr = 3'd1; upd_potential = 32'h12345678;
        chk("upd_ready_in_sweep", 32'(upd_ready), 32'd0);
        out_ready = 1'b0;
        tick();
        upd_valid = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
        wait_done(3, 3);
        chk("lit_upd_at_start", got[2], 32'h3F800000);

        // Sweep 4 confirms memory was untouched by the ignored update.
        do_start();
        wait_done(4, 4);
        chk("lit_upd_ignored", got[1], 32'h41DED852);

        // Reset mid-sweep aborts with no done pulse.
        do_start();
        tick();
        tick();
        rst = 1'b1;
        tick();
        model_reset();
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_addr", 32'(out_addr), 32'd0);
        chk("abort_out_pot", out_potential, 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ts", 32'(ts_count), 32'd0);
        chk("abort_upd_ready", 32'(upd_ready), 32'd1);
        rst = 1'b0;
        repeat (10) tick();
        chk("abort_no_done", 32'(done_cnt), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000, expected earlier finish");
        $fatal(1, "timeout");
    end
endmodule
